// File: rtl/encdec_pkg.sv
// Shared constants and state encoding for the 16-to-4 serial priority encoder.
package encdec_pkg;
  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {IDLE, BUSY} enc_state_t;
endpackage

// File: rtl/encoder16to4_serial_encoder4to2.sv
// Combinational 4-to-2 priority encoder: index of the lowest set bit plus an any flag.
module encoder4to2 (
  input  logic [3:0] a,
  output logic [1:0] idx,
  output logic       any
);
  always_comb begin
    idx = 2'd0;
    any = |a;
    if (a[0])      idx = 2'd0;
    else if (a[1]) idx = 2'd1;
    else if (a[2]) idx = 2'd2;
    else if (a[3]) idx = 2'd3;
  end
endmodule

// File: rtl/encoder16to4_serial.sv
// Sequential 16-to-4 priority encoder: accepts a multi-hot vector, then streams
// the index of every set bit, lowest first, one per output handshake.
module encoder16to4_serial
  import encdec_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_REQ-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic             none
);
  enc_state_t       r_state;
  enc_state_t       w_state_next;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] w_pending_next;
  logic             r_none;
  logic             w_none_next;

  logic [1:0]       w_nib_idx [4];
  logic [3:0]       w_nib_any;
  logic [1:0]       w_top_idx;
  logic             w_any_all;
  logic [N_REQ-1:0] w_pending_clr;
  logic [IDX_W-1:0] w_idx_raw;
  logic             w_last_raw;

  // Two-level tree: one encoder per nibble, then one over the nibble any flags.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      encoder4to2 u_nib (
        .a   (r_pending[gi*4 +: 4]),
        .idx (w_nib_idx[gi]),
        .any (w_nib_any[gi])
      );
    end
  endgenerate

  encoder4to2 u_top (
    .a   (w_nib_any),
    .idx (w_top_idx),
    .any (w_any_all)
  );

  assign w_idx_raw     = {w_top_idx, w_nib_idx[w_top_idx]};
  assign w_pending_clr = r_pending & (r_pending - 16'd1);
  assign w_last_raw    = w_any_all && (w_pending_clr == '0);

  assign out_valid = (r_state == BUSY);
  assign in_ready  = (r_state == IDLE) && !rst;
  assign idx       = out_valid ? w_idx_raw : '0;
  assign last      = out_valid && w_last_raw;
  assign none      = r_none;

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_none_next    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (req != '0) begin
            w_pending_next = req;
            w_state_next   = BUSY;
          end else begin
            w_none_next = 1'b1;
          end
        end
      end
      BUSY: begin
        if (out_ready) begin
          // Clearing the lowest set bit is exactly clearing bit idx.
          w_pending_next = w_pending_clr;
          if (w_last_raw) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_none    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_none    <= w_none_next;
    end
  end
endmodule

// File: tb/tb_encoder16to4_serial.sv
// Directed bench for encoder16to4_serial with hand-computed expectations.
module tb_encoder16to4_serial;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] req;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  idx;
  logic        last;
  logic        none;

  int n_cmp;
  int n_err;

  encoder16to4_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idx       (idx),
    .last      (last),
    .none      (none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected index sequence for 16'h8421
  int seq_8421 [4] = '{0, 5, 10, 15};

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    req       = 16'h0000;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_idx", idx, 0);
    chk("rst_last", last, 0);
    chk("rst_none", none, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    $display("txn reset done");

    // Single top bit
    req = 16'h8000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_idx", idx, 15);
    chk("t1_last", last, 1);
    chk("t1_in_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("t1_done_valid", out_valid, 0);
    chk("t1_done_ready", in_ready, 1);
    out_ready = 1'b0;
    $display("txn req=8000 done");

    // Spread bits, continuous drain
    req = 16'h8421; in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", out_valid, 1);
      chk("t2_idx", idx, seq_8421[i]);
      chk("t2_last", last, (i == 3) ? 1 : 0);
      step();
    end
    chk("t2_done_valid", out_valid, 0);
    out_ready = 1'b0;
    $display("txn req=8421 done");

    // Backpressure
    req = 16'h0003; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_valid", out_valid, 1);
      chk("t3_hold_idx", idx, 0);
      chk("t3_hold_last", last, 0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("t3_first_idx", idx, 0);
    chk("t3_first_last", last, 0);
    step();
    chk("t3_second_idx", idx, 1);
    chk("t3_second_last", last, 1);
    step();
    chk("t3_done_valid", out_valid, 0);
    out_ready = 1'b0;
    $display("txn req=0003 backpressure done");

    // Empty vector
    req = 16'h0000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t4_none_hi", none, 1);
    chk("t4_valid", out_valid, 0);
    chk("t4_ready", in_ready, 1);
    step();
    chk("t4_none_lo", none, 0);
    chk("t4_valid2", out_valid, 0);
    chk("t4_ready2", in_ready, 1);
    $display("txn req=0000 done");

    // All ones with a second vector waiting
    req = 16'hFFFF; in_valid = 1'b1;
    step();
    req = 16'h0001;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t5_valid", out_valid, 1);
      chk("t5_idx", idx, i);
      chk("t5_last", last, (i == 15) ? 1 : 0);
      chk("t5_in_ready", in_ready, 0);
      step();
    end
    chk("t5_gap_valid", out_valid, 0);
    chk("t5_gap_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("t5_next_valid", out_valid, 1);
    chk("t5_next_idx", idx, 0);
    chk("t5_next_last", last, 1);
    step();
    chk("t5_end_valid", out_valid, 0);
    out_ready = 1'b0;
    $display("txn req=FFFF then 0001 done");

    // Reset mid-vector
    req = 16'h00F0; in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t6_first_idx", idx, 4);
    step();
    chk("t6_second_idx", idx, 5);
    rst = 1'b1; out_ready = 1'b0;
    step();
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_idx", idx, 0);
    chk("t6_rst_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("t6_rel_ready", in_ready, 1);
    chk("t6_rel_valid", out_valid, 0);
    step();
    chk("t6_idle_valid", out_valid, 0);
    req = 16'h0100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t6_new_idx", idx, 8);
    chk("t6_new_last", last, 1);
    out_ready = 1'b1;
    step();
    chk("t6_new_done", out_valid, 0);
    out_ready = 1'b0;
    $display("txn req=00F0 reset abort then 0100 done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/encoder16to4_serial.md
# encoder16to4_serial

Sequential 16-to-4 priority encoder, the inverse companion of the team's 4-to-16 decoder tree. Accepts a 16-bit multi-hot request vector through a valid/ready handshake, then emits the 4-bit index of every set bit, lowest index first, one per output handshake. Used wherever a decoded vector, such as interrupt lines or per-slot flags, must be turned back into a stream of binary indices for downstream logic.

## Interface
Parameters:
- None. Vector width 16 and index width 4 are fixed by package constants.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  request vector on `req` is valid
- in_ready  output  1  block can accept a vector
- req  input  16  request vector; bit k set means index k pending
- out_valid  output  1  `idx` holds a valid index
- out_ready  input  1  consumer accepts `idx` this cycle
- idx  output  4  encoded index of lowest pending bit
- last  output  1  current `idx` is the final pending bit of this vector
- none  output  1  one-cycle pulse: an all-zero vector was accepted

## Operation
- Two states: IDLE and BUSY. Internal 16-bit `pending` register.
- IDLE:
  - `in_ready` = 1 and `out_valid` = 0.
  - Accept occurs when `in_valid && in_ready`.
  - Accepting a vector with `req != 0` loads `pending <= req` and moves to BUSY.
  - Accepting `req == 0` stays in IDLE, leaves `pending` at 0, and pulses `none` for one cycle.
- BUSY:
  - `in_ready` = 0. `in_valid` is ignored and `req` is not sampled.
  - `out_valid` = 1.
  - `idx` = position of the lowest set bit of `pending`.
  - `last` = 1 when `pending` has exactly one bit set.
- Output handshake (`out_valid && out_ready`): clears bit `idx` of `pending`.
  - If `last` = 1: go to IDLE; `pending` becomes 0.
  - Otherwise stay in BUSY.
- Backpressure: while `out_ready` = 0, `pending`, `idx` and `last` hold stable.
- When `out_valid` = 0: `idx` = 0 and `last` = 0.
- Priority is strictly ascending, lowest index first, with no rotation or fairness.

## Timing
- Reset (`rst` high at a rising edge):
  - State goes to IDLE, `pending` = 0, `none` = 0.
  - `out_valid`, `idx` and `last` read 0.
  - `in_ready` = 0 while `rst` is high and 1 in the first cycle after release.
- Reset mid-operation aborts the vector. Remaining pending bits are discarded and no further `out_valid` appears.
- Accept at edge N gives `out_valid` = 1 in cycle N+1 (latency 1). `none` is high in cycle N+1 only.
- `idx` and `last` are combinational from the registered `pending`, with no path from `in_*`. `out_valid` and `in_ready` come from the state register only.
- A vector with k set bits needs exactly k output handshakes.
  - With `out_ready` held at 1 it occupies k cycles.
  - The next vector can be accepted in the cycle after the final handshake, so throughput is k+1 cycles per vector.
- `out_ready` may be high when `out_valid` = 0. This has no effect.

## Structure
- Package `encdec_pkg`:
  - `localparam N_REQ = 16` and `localparam IDX_W = 4`.
  - `typedef enum logic {IDLE, BUSY} enc_state_t`.
- Sub-module `encoder4to2`, a combinational priority encoder:
  - Ports: `a[3:0]`, `idx[1:0]` (lowest set bit), `any`.
  - Five instances form a tree:
    - Four instances cover the nibbles of `pending`.
    - One instance takes the four `any` outputs.
    - The final index is {upper 2 bits from the top encoder, lower 2 bits from the selected nibble encoder}. This mirrors the 2-to-4 decoder tree.
- `last` is computed as `(pending & (pending - 1)) == 0` while `pending` is nonzero. The clear-mask uses `pending & (pending - 1)`.

## Test plan
- Reset, then `req` = 16'h8000 → `out_valid` in the next cycle with `idx` = 15 and `last` = 1; one handshake returns to IDLE with `in_ready` = 1.
- `req` = 16'h8421 with `out_ready` held at 1 → `idx` sequence 0, 5, 10, 15 on consecutive cycles; `last` = 1 only on 15.
- `req` = 16'h0003 with `out_ready` = 0 for 5 cycles → `idx` = 0 and `last` = 0 held stable; after release, outputs 0 then 1 (`last` = 1).
- `req` = 16'h0000 → `none` high for exactly one cycle, `out_valid` never asserts, `in_ready` stays 1.
- `req` = 16'hFFFF with `in_valid` held high throughout BUSY carrying 16'h0001 → 16 outputs 0..15; the second vector is accepted only after `last`, then outputs `idx` = 0.
- `req` = 16'h00F0, `rst` pulsed after the first output (`idx` = 4) → outputs 0 after reset, `in_ready` = 1; a new `req` of 16'h0100 yields `idx` = 8.
